// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, blank pattern
// and the active-low hex-to-segment table ({g,f,e,d,c,b,a}).
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern lookup.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with a frame-latched shadow value.
// Optional leading-zero blanking of digits 3..1 is enabled by defining SEG_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] num,
    output logic [3:0]  sp_led_select,
    output logic [6:0]  sp_led,
    output logic        frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          slot_tick;
    logic          frame_wrap;
    logic [3:0]    nibble_d;
    logic [6:0]    seg_dec;
    logic          blank_d;
    logic [3:0]    sel_d;
    logic [6:0]    led_d;

    // Outputs are computed from next-state index/shadow so they flip on the
    // same edge as the index, and the frame-boundary edge shows the new num.
    always_comb begin
        slot_tick  = (presc_q == CW'(SCAN_DIV - 1));
        presc_d    = slot_tick ? '0 : presc_q + CW'(1);
        idx_d      = slot_tick ? idx_q + 2'd1 : idx_q;
        frame_wrap = slot_tick && (idx_q == 2'd3);
        shadow_d   = frame_wrap ? num : shadow_q;
        nibble_d   = 4'(shadow_d >> {idx_d, 2'b00});
    end

    seg_hex_decode u_dec (
        .hex_i (nibble_d),
        .seg_o (seg_dec)
    );

`ifdef SEG_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_above;

    assign zero_above[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_zero_above
        assign zero_above[gi] = (shadow_d[15:4*gi] == '0);
    end

    assign blank_d = zero_above[idx_d];
`else
    assign blank_d = 1'b0;
`endif

    always_comb begin
        sel_d = blank_d ? 4'b1111 : ~(4'b0001 << idx_d);
        led_d = blank_d ? SEG_BLANK : seg_dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            idx_q         <= 2'd0;
            shadow_q      <= 16'h0000;
            sp_led_select <= 4'b1110;
            sp_led        <= SEG_TABLE[0];
            frame_tick    <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            sp_led_select <= sel_d;
            sp_led        <= led_d;
            frame_tick    <= frame_wrap;
        end
    end

endmodule
